// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED matrix frame controller.
//   LED_COLS / LED_ROWS : matrix geometry (4 columns x 8 rows)
//   led_col_t           : column index
//   led_row_t           : one column's row bits
//   req_idx_e           : requester identity (REQ_A = CPU debug, REQ_B = status)
// -----------------------------------------------------------------------------
package led_pkg;

   localparam int LED_COLS = 4;
   localparam int LED_ROWS = 8;

   typedef logic [$clog2(LED_COLS)-1:0] led_col_t;
   typedef logic [LED_ROWS-1:0]         led_row_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_idx_e;

endpackage

// File: rtl/led_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// led_frame_ctrl_if
// Column-write handshake for both requesters of led_frame_ctrl.
//   x_req    : write request, level, held until ack
//   x_col    : target column
//   x_data   : row bits for that column
//   x_commit : single-cycle pulse, back buffer complete
//   x_ack    : single-cycle write acknowledge (driven by the controller)
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface led_frame_ctrl_if;
   import led_pkg::*;

   logic     a_req;
   led_col_t a_col;
   led_row_t a_data;
   logic     a_commit;
   logic     a_ack;

   logic     b_req;
   led_col_t b_col;
   led_row_t b_data;
   logic     b_commit;
   logic     b_ack;

   modport master (
      output a_req, a_col, a_data, a_commit,
      output b_req, b_col, b_data, b_commit,
      input  a_ack, b_ack
   );

   modport slave (
      input  a_req, a_col, a_data, a_commit,
      input  b_req, b_col, b_data, b_commit,
      output a_ack, b_ack
   );

endinterface

// File: rtl/led_rr_arb.sv
// -----------------------------------------------------------------------------
// led_rr_arb
// Two-way write arbiter with ack masking. A requester is eligible only while
// its req is high and its ack is low, so a held req cannot write twice.
// Conflict resolution:
//   LEDCTRL_RR_EN defined   : round-robin, pointer moves only on a conflict
//   LEDCTRL_RR_EN undefined : fixed priority, A beats B, no pointer register
// Ports:
//   clk12MHz, reset : clock, async active-high reset
//   a_req, b_req    : request levels
//   a_grant, b_grant: combinational grant for the current cycle
//   a_ack, b_ack    : registered acks, high the cycle after a grant
// -----------------------------------------------------------------------------
module led_rr_arb
   import led_pkg::*;
(
   input  logic clk12MHz,
   input  logic reset,
   input  logic a_req,
   input  logic b_req,
   output logic a_grant,
   output logic b_grant,
   output logic a_ack,
   output logic b_ack
);

   logic a_elig;
   logic b_elig;

   assign a_elig = a_req & ~a_ack;
   assign b_elig = b_req & ~b_ack;

`ifdef LEDCTRL_RR_EN
   req_idx_e favour;

   // After a conflict the winner loses priority to the other requester.
   always_ff @(posedge clk12MHz or posedge reset) begin
      if (reset)
         favour <= REQ_A;
      else if (a_elig && b_elig)
         favour <= (favour == REQ_A) ? REQ_B : REQ_A;
   end

   always_comb begin
      a_grant = a_elig & (~b_elig | (favour == REQ_A));
      b_grant = b_elig & (~a_elig | (favour == REQ_B));
   end
`else
   assign a_grant = a_elig;
   assign b_grant = b_elig & ~a_elig;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk12MHz or posedge reset) begin
      if (reset) begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
      end else begin
         a_ack <= a_grant;
         b_ack <= b_grant;
      end
   end

endmodule

// File: rtl/led_frame_ctrl.sv
// -----------------------------------------------------------------------------
// led_frame_ctrl
// Double-buffered frame controller for the 4x8 LED matrix. Column writes from
// two requesters land in a back buffer; a commit marks it complete and the
// back buffer is copied to the displayed front buffer on the last cycle of a
// scan frame, so the scanner never shows a half-updated image.
// Optional feature macro: LEDCTRL_RR_EN (round-robin arbitration in led_rr_arb).
// Ports:
//   clk12MHz, reset      : clock, async active-high reset
//   bus (slave)          : A/B req/col/data/commit in, ack out
//   leds1..leds4         : front buffer columns 0..3
//   scan_col             : column currently scanned (top 2 counter bits)
//   frame_tick           : high on the last cycle of each frame
//   swap_pending         : a commit is waiting for the next frame boundary
// -----------------------------------------------------------------------------
module led_frame_ctrl
   import led_pkg::*;
#(
   parameter int SCAN_BITS = 12
) (
   input  logic                   clk12MHz,
   input  logic                   reset,
   led_frame_ctrl_if.slave        bus,
   output led_row_t               leds1,
   output led_row_t               leds2,
   output led_row_t               leds3,
   output led_row_t               leds4,
   output led_col_t               scan_col,
   output logic                   frame_tick,
   output logic                   swap_pending
);

   // Count value one cycle before the frame's last cycle; frame_tick is
   // registered from it so the tick coincides with the all-ones count.
   localparam logic [SCAN_BITS-1:0] SCAN_PRE_LAST = {{(SCAN_BITS-1){1'b1}}, 1'b0};

   logic [SCAN_BITS-1:0] scan_cnt;
   logic                 tick_q;
   logic                 pending_q;
   led_row_t             back  [LED_COLS];
   led_row_t             front [LED_COLS];

   logic     a_grant;
   logic     b_grant;
   logic     wr_en;
   led_col_t wr_col;
   led_row_t wr_data;

   led_rr_arb u_arb (
      .clk12MHz (clk12MHz),
      .reset    (reset),
      .a_req    (bus.a_req),
      .b_req    (bus.b_req),
      .a_grant  (a_grant),
      .b_grant  (b_grant),
      .a_ack    (bus.a_ack),
      .b_ack    (bus.b_ack)
   );

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      wr_en   = a_grant | b_grant;
      wr_col  = bus.b_col;
      wr_data = bus.b_data;
      if (a_grant) begin
         wr_col  = bus.a_col;
         wr_data = bus.a_data;
      end
   end

   always_ff @(posedge clk12MHz or posedge reset) begin
      if (reset) begin
         scan_cnt <= '0;
         tick_q   <= 1'b0;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
         tick_q   <= (scan_cnt == SCAN_PRE_LAST);
      end
   end

   // A commit always arms the next boundary, even one arriving on the tick
   // cycle while an earlier commit is being swapped.
   always_ff @(posedge clk12MHz or posedge reset) begin
      if (reset)
         pending_q <= 1'b0;
      else
         pending_q <= (pending_q & ~tick_q) | bus.a_commit | bus.b_commit;
   end

   // NOTE: the buffers are small register arrays that must read as zero
   // after reset, so they sit in the reset branch like any other flop.
   // The swap copies pre-edge back contents; a write in the same cycle
   // shows up only on the following swap.
   always_ff @(posedge clk12MHz or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LED_COLS; i++) begin
            back[i]  <= '0;
            front[i] <= '0;
         end
      end else begin
         if (wr_en)
            back[wr_col] <= wr_data;
         if (tick_q && pending_q) begin
            for (int i = 0; i < LED_COLS; i++)
               front[i] <= back[i];
         end
      end
   end

   assign leds1        = front[0];
   assign leds2        = front[1];
   assign leds3        = front[2];
   assign leds4        = front[3];
   assign scan_col     = scan_cnt[SCAN_BITS-1 -: 2];
   assign frame_tick   = tick_q;
   assign swap_pending = pending_q;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_frame_ctrl
// Directed bench for led_frame_ctrl with SCAN_BITS = 4 (16-cycle frames).
// Inputs are driven 1 ns after the rising edge and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_led_frame_ctrl;
   import led_pkg::*;

   localparam int SB    = 4;
   localparam int FRAME = 1 << SB;

   logic     clk12MHz = 1'b0;
   logic     reset    = 1'b1;
   led_row_t leds1, leds2, leds3, leds4;
   led_col_t scan_col;
   logic     frame_tick;
   logic     swap_pending;

   led_frame_ctrl_if bus ();

   led_frame_ctrl #(.SCAN_BITS(SB)) dut (
      .clk12MHz     (clk12MHz),
      .reset        (reset),
      .bus          (bus.slave),
      .leds1        (leds1),
      .leds2        (leds2),
      .leds3        (leds3),
      .leds4        (leds4),
      .scan_col     (scan_col),
      .frame_tick   (frame_tick),
      .swap_pending (swap_pending)
   );

   always #5 clk12MHz = ~clk12MHz;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;   // rising edges since reset release

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk12MHz);
      #1;
      cyc++;
   endtask

   // Advance until the scan counter equals cnt (bounded to two frames).
   task automatic run_to(input int cnt);
      for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != cnt; i++)
         step();
      check("run_to", cyc % FRAME, cnt);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk12MHz);
      @(posedge clk12MHz);
      #1;
      reset = 1'b0;
      cyc   = 0;
   endtask

   initial begin
      bus.a_req = 0; bus.a_col = 0; bus.a_data = 0; bus.a_commit = 0;
      bus.b_req = 0; bus.b_col = 0; bus.b_data = 0; bus.b_commit = 0;
      do_reset();

      // ---- reset state ----
      check("rst_leds1", leds1, 8'h00);
      check("rst_leds2", leds2, 8'h00);
      check("rst_leds3", leds3, 8'h00);
      check("rst_leds4", leds4, 8'h00);
      check("rst_scan_col", scan_col, 0);
      check("rst_tick", frame_tick, 0);
      check("rst_pending", swap_pending, 0);
      check("rst_a_ack", bus.a_ack, 0);
      check("rst_b_ack", bus.b_ack, 0);

      // ---- one idle frame: scan_col steps every 4 cycles, tick at count 15 ----
      for (int i = 1; i <= FRAME; i++) begin
         step();
         check("frame_scan_col", scan_col, (i % FRAME) >> 2);
         check("frame_tick", frame_tick, (i % FRAME) == FRAME - 1);
         check("frame_leds1", leds1, 8'h00);
      end

      // ---- A writes col0=A5, col3=3C, commits mid-frame ----
      bus.a_req = 1; bus.a_col = 2'd0; bus.a_data = 8'hA5;
      step();
      check("a_wr0_ack", bus.a_ack, 1);
      bus.a_req = 0;
      step();
      check("a_ack_drop", bus.a_ack, 0);
      bus.a_req = 1; bus.a_col = 2'd3; bus.a_data = 8'h3C;
      step();
      check("a_wr3_ack", bus.a_ack, 1);
      bus.a_req = 0;
      bus.a_commit = 1;
      step();
      bus.a_commit = 0;
      check("commit_pending", swap_pending, 1);
      check("commit_leds1_hold", leds1, 8'h00);
      run_to(FRAME - 1);
      check("swap_tick", frame_tick, 1);
      check("swap_pre_leds1", leds1, 8'h00);
      check("swap_pre_leds4", leds4, 8'h00);
      step();
      check("swap_leds1", leds1, 8'hA5);
      check("swap_leds2", leds2, 8'h00);
      check("swap_leds4", leds4, 8'h3C);
      check("swap_pending_clr", swap_pending, 0);
      check("swap_scan_wrap", scan_col, 0);

      // ---- A and B both request continuously on col2 ----
      // A wins the first (conflicting) edge in both arbiter builds; after
      // that each ack masks its owner, so the grants alternate A,B,A,B.
      bus.a_req = 1; bus.a_col = 2'd2; bus.a_data = 8'h11;
      bus.b_req = 1; bus.b_col = 2'd2; bus.b_data = 8'h22;
      for (int i = 0; i < 4; i++) begin
         step();
         check("both_a_ack", bus.a_ack, (i % 2) == 0);
         check("both_b_ack", bus.b_ack, (i % 2) == 1);
      end
      bus.a_req = 0; bus.b_req = 0;
      step();
      check("both_a_idle", bus.a_ack, 0);
      check("both_b_idle", bus.b_ack, 0);
      check("both_no_commit", swap_pending, 0);

      // ---- B writes col1=FF and commits on the frame_tick cycle ----
      run_to(FRAME - 1);
      check("b_tick", frame_tick, 1);
      bus.b_req = 1; bus.b_col = 2'd1; bus.b_data = 8'hFF; bus.b_commit = 1;
      step();
      bus.b_req = 0; bus.b_commit = 0;
      check("b_ack", bus.b_ack, 1);
      check("b_pending", swap_pending, 1);
      check("b_no_swap_leds2", leds2, 8'h00);
      check("b_no_swap_leds3", leds3, 8'h00);
      run_to(FRAME - 1);
      check("b_pre_leds2", leds2, 8'h00);
      step();
      check("b_leds2", leds2, 8'hFF);
      check("b_leds3_last_wins", leds3, 8'h22);
      check("b_leds1_kept", leds1, 8'hA5);
      check("b_leds4_kept", leds4, 8'h3C);
      check("b_pending_clr", swap_pending, 0);

      // ---- commit, then reset 3 cycles later with an ack in flight ----
      step();
      bus.a_commit = 1;
      step();
      bus.a_commit = 0;
      check("rc_pending", swap_pending, 1);
      step();
      bus.a_req = 1; bus.a_col = 2'd0; bus.a_data = 8'h77;
      step();
      bus.a_req = 0;
      check("rc_ack_inflight", bus.a_ack, 1);
      reset = 1'b1;
      #1;
      check("rc_async_pending", swap_pending, 0);
      check("rc_async_ack", bus.a_ack, 0);
      check("rc_async_leds1", leds1, 8'h00);
      check("rc_async_leds2", leds2, 8'h00);
      check("rc_async_scan", scan_col, 0);
      @(posedge clk12MHz);
      #1;
      reset = 1'b0;
      cyc   = 0;
      run_to(FRAME - 1);
      check("rc_first_tick", frame_tick, 1);
      check("rc_tick_leds1", leds1, 8'h00);
      step();
      check("rc_post_leds1", leds1, 8'h00);
      check("rc_post_leds2", leds2, 8'h00);
      check("rc_post_leds4", leds4, 8'h00);
      check("rc_post_pending", swap_pending, 0);
      check("rc_post_tick", frame_tick, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
